id_ex_reg: RTL
==============

// Module: id_ex_reg
// PURPOSE
//   ID/EX pipeline register of the 5-stage MIPS core. Captures decoded ID-stage operands and control,
//   and presents them as the EX_* signals the hazard controller and EX datapath consume.
//   Inserts a bubble when the hazard controller raises ID_clr, and holds when EX_stall is high.
//   Ages the producer timing tag (Tnew) by one stage as the instruction crosses the boundary.
// PARAMETERS
//   DW      32  datapath width: PC, operands, immediate
//   TW      4   Tnew width; matches the hazard controller's Tnew/Tuse ports
// PORTS
//   clk           in   1   core clock; all state updates on posedge
//   rst_n         in   1   synchronous, active-low reset
//   ID_clr        in   1   bubble request from hazard controller (stall of IF/ID)
//   EX_stall      in   1   hold request from EX (multi-cycle mult/div busy)
//   ID_PC         in   DW  PC of instruction in ID
//   ID_RD1/ID_RD2 in   DW  forwarded rs/rt operands (after FowardAD/FowardBD mux)
//   ID_Ext        in   DW  extended immediate
//   ID_Rs/ID_Rt   in   5   source register numbers
//   ID_WA         in   5   destination register number
//   ID_RegWrite   in   1   writes GPR
//   ID_MemtoReg   in   1   load
//   ID_MemWrite   in   1   store
//   ID_ALUSrc     in   1   1: B operand = ID_Ext
//   ID_ALUCtrl    in   4   ALU opcode
//   ID_Tnew       in   TW  cycles from ID until result is produced
//   EX_*          out  —   registered copies of every ID_* above (same widths)
//   EX_valid      out  1   1: real instruction in EX; 0: bubble
//   bubble_cnt    out  32  bubbles inserted (perf; see CONFIGURATION)
//   hold_cnt      out  32  EX_stall hold cycles (perf; see CONFIGURATION)
// BEHAVIOUR
//   - Priority per posedge: !rst_n > EX_stall > ID_clr > load.
//   - Reset (rst_n==0 at posedge): all EX_* outputs = 0, EX_valid = 0, counters = 0.
//     Reset mid-stall or mid-bubble wins unconditionally.
//   - Hold (EX_stall==1): every register keeps its value. ID_clr is ignored that cycle;
//     the hazard controller keeps ID_clr asserted while the hazard persists.
//   - Bubble (ID_clr==1, EX_stall==0):
//     - EX_PC <= ID_PC.
//     - All other EX_* <= 0: WA=0, RegWrite=0, MemtoReg=0, MemWrite=0, Tnew=0, Rs=Rt=0.
//     - EX_valid <= 0.
//     - A bubble never matches a forwarding/stall comparison, because WA==0.
//   - Load (ID_clr==0, EX_stall==0):
//     - All EX_* <= ID_*, with these exceptions:
//       - EX_RegWrite <= ID_RegWrite & (ID_WA!=0).
//       - EX_Tnew <= (ID_Tnew==0) ? 0 : ID_Tnew-1 (saturating, TW bits, no wrap).
//     - EX_valid <= 1.
//   - Latency: exactly 1 cycle ID -> EX. No combinational path from any input to any output.
//   - EX_MemtoReg and EX_MemWrite are never both 1 after load:
//     if both inputs are 1, EX_MemWrite wins and EX_MemtoReg <= 0.
// CONFIGURATION
//   - ID_EX_PERF_EN defined:
//     - bubble_cnt increments on every bubble cycle.
//     - hold_cnt increments on every hold cycle.
//     - Both are 32-bit, saturate at 32'hFFFF_FFFF, and clear only on reset.
//   - ID_EX_PERF_EN undefined: bubble_cnt = hold_cnt = 0 constantly; no counter flops are synthesized.
// TESTING
//   1. rst_n=0 for 2 cycles with random ID_* -> all EX_* = 0, EX_valid=0 at the first posedge.
//   2. Load: ID_WA=5'd8, ID_RegWrite=1, ID_Tnew=3, ID_PC=32'h3000 ->
//      next cycle EX_WA=8, EX_RegWrite=1, EX_Tnew=2, EX_PC=32'h3000, EX_valid=1.
//   3. ID_clr=1 with ID_PC=32'h3004, ID_WA=9 ->
//      EX_WA=0, EX_RegWrite=0, EX_Tnew=0, EX_PC=32'h3004, EX_valid=0;
//      with ID_EX_PERF_EN, bubble_cnt 0->1.
//   4. EX_stall=1 and ID_clr=1 for 3 cycles after a load ->
//      EX_* unchanged all 3 cycles; hold_cnt=3 and bubble_cnt unchanged (with ID_EX_PERF_EN).
//   5. Edge cases:
//      - ID_Tnew=0 -> EX_Tnew=0 (no wrap to 4'hF).
//      - ID_WA=0 with ID_RegWrite=1 -> EX_RegWrite=0.
//      - ID_MemtoReg=ID_MemWrite=1 -> EX_MemWrite=1, EX_MemtoReg=0.
//   6. rst_n=0 asserted during an EX_stall hold -> outputs zeroed next posedge; load resumes once rst_n=1.

Source files
------------

// File: rtl/id_ex_reg_if.sv
// ID/EX boundary bundle: decoded ID-stage fields in, registered EX-stage copies out.
// The master side (ID stage / hazard controller) drives ID_*, ID_clr and EX_stall.
interface id_ex_reg_if #(
  parameter int DW = 32,
  parameter int TW = 4
);
  logic          ID_clr;
  logic          EX_stall;
  logic [DW-1:0] ID_PC;
  logic [DW-1:0] ID_RD1;
  logic [DW-1:0] ID_RD2;
  logic [DW-1:0] ID_Ext;
  logic [4:0]    ID_Rs;
  logic [4:0]    ID_Rt;
  logic [4:0]    ID_WA;
  logic          ID_RegWrite;
  logic          ID_MemtoReg;
  logic          ID_MemWrite;
  logic          ID_ALUSrc;
  logic [3:0]    ID_ALUCtrl;
  logic [TW-1:0] ID_Tnew;

  // EX_valid=1 means the EX_* fields describe a real instruction; 0 marks a
  // bubble (or reset), whose WA=0 keeps it out of every hazard comparison.
  logic [DW-1:0] EX_PC;
  logic [DW-1:0] EX_RD1;
  logic [DW-1:0] EX_RD2;
  logic [DW-1:0] EX_Ext;
  logic [4:0]    EX_Rs;
  logic [4:0]    EX_Rt;
  logic [4:0]    EX_WA;
  logic          EX_RegWrite;
  logic          EX_MemtoReg;
  logic          EX_MemWrite;
  logic          EX_ALUSrc;
  logic [3:0]    EX_ALUCtrl;
  logic [TW-1:0] EX_Tnew;
  logic          EX_valid;

  modport master (
    output ID_clr, EX_stall, ID_PC, ID_RD1, ID_RD2, ID_Ext, ID_Rs, ID_Rt, ID_WA,
           ID_RegWrite, ID_MemtoReg, ID_MemWrite, ID_ALUSrc, ID_ALUCtrl, ID_Tnew,
    input  EX_PC, EX_RD1, EX_RD2, EX_Ext, EX_Rs, EX_Rt, EX_WA, EX_RegWrite,
           EX_MemtoReg, EX_MemWrite, EX_ALUSrc, EX_ALUCtrl, EX_Tnew, EX_valid
  );

  modport slave (
    input  ID_clr, EX_stall, ID_PC, ID_RD1, ID_RD2, ID_Ext, ID_Rs, ID_Rt, ID_WA,
           ID_RegWrite, ID_MemtoReg, ID_MemWrite, ID_ALUSrc, ID_ALUCtrl, ID_Tnew,
    output EX_PC, EX_RD1, EX_RD2, EX_Ext, EX_Rs, EX_Rt, EX_WA, EX_RegWrite,
           EX_MemtoReg, EX_MemWrite, EX_ALUSrc, EX_ALUCtrl, EX_Tnew, EX_valid
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: load / bubble / hold with Tnew aging.
// Optional perf counters (bubble_cnt, hold_cnt) are built only when ID_EX_PERF_EN is defined.
module id_ex_reg #(
  parameter int DW = 32,
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_reg_if.slave    bus,
  output logic [31:0]   bubble_cnt,
  output logic [31:0]   hold_cnt
);

  // Priority: reset > hold > bubble > load. Hold simply leaves every flop alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.EX_PC       <= {DW{1'b0}};
      bus.EX_RD1      <= {DW{1'b0}};
      bus.EX_RD2      <= {DW{1'b0}};
      bus.EX_Ext      <= {DW{1'b0}};
      bus.EX_Rs       <= 5'd0;
      bus.EX_Rt       <= 5'd0;
      bus.EX_WA       <= 5'd0;
      bus.EX_RegWrite <= 1'b0;
      bus.EX_MemtoReg <= 1'b0;
      bus.EX_MemWrite <= 1'b0;
      bus.EX_ALUSrc   <= 1'b0;
      bus.EX_ALUCtrl  <= 4'd0;
      bus.EX_Tnew     <= {TW{1'b0}};
      bus.EX_valid    <= 1'b0;
    end else if (!bus.EX_stall) begin
      if (bus.ID_clr) begin
        // Bubble keeps its PC so exception/debug logic still sees where it sits.
        bus.EX_PC       <= bus.ID_PC;
        bus.EX_RD1      <= {DW{1'b0}};
        bus.EX_RD2      <= {DW{1'b0}};
        bus.EX_Ext      <= {DW{1'b0}};
        bus.EX_Rs       <= 5'd0;
        bus.EX_Rt       <= 5'd0;
        bus.EX_WA       <= 5'd0;
        bus.EX_RegWrite <= 1'b0;
        bus.EX_MemtoReg <= 1'b0;
        bus.EX_MemWrite <= 1'b0;
        bus.EX_ALUSrc   <= 1'b0;
        bus.EX_ALUCtrl  <= 4'd0;
        bus.EX_Tnew     <= {TW{1'b0}};
        bus.EX_valid    <= 1'b0;
      end else begin
        bus.EX_PC       <= bus.ID_PC;
        bus.EX_RD1      <= bus.ID_RD1;
        bus.EX_RD2      <= bus.ID_RD2;
        bus.EX_Ext      <= bus.ID_Ext;
        bus.EX_Rs       <= bus.ID_Rs;
        bus.EX_Rt       <= bus.ID_Rt;
        bus.EX_WA       <= bus.ID_WA;
        // Writes to $zero are dropped here so forwarding never sources from r0.
        bus.EX_RegWrite <= bus.ID_RegWrite & (bus.ID_WA != 5'd0);
        bus.EX_MemtoReg <= bus.ID_MemtoReg & ~bus.ID_MemWrite;
        bus.EX_MemWrite <= bus.ID_MemWrite;
        bus.EX_ALUSrc   <= bus.ID_ALUSrc;
        bus.EX_ALUCtrl  <= bus.ID_ALUCtrl;
        bus.EX_Tnew     <= (bus.ID_Tnew == {TW{1'b0}}) ? {TW{1'b0}} : bus.ID_Tnew - TW'(1);
        bus.EX_valid    <= 1'b1;
      end
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_q;
  logic [31:0] hold_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_q <= 32'd0;
      hold_q   <= 32'd0;
    end else if (bus.EX_stall) begin
      if (hold_q != 32'hFFFF_FFFF) hold_q <= hold_q + 32'd1;
    end else if (bus.ID_clr) begin
      if (bubble_q != 32'hFFFF_FFFF) bubble_q <= bubble_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_q;
  assign hold_cnt   = hold_q;
`else
  assign bubble_cnt = 32'd0;
  assign hold_cnt   = 32'd0;
`endif

endmodule
